if_stage_mq: RTL
================

// Module: if_stage_mq
// PURPOSE
//  Parametrised instruction-fetch stage: keeps up to MAX_OUTST reads in flight on the
//  SRAM-like inst bus and buffers returned instructions in an IQ_DEPTH-entry queue ahead of ID.
//  Redirects (exception, ertn, branch) flush the queue and discard stale in-flight responses
//  by count. Sits between the inst SRAM/AXI bridge and ID_stage.
// PARAMETERS
//  MAX_OUTST  2             max accepted-but-unanswered requests (1..4)
//  IQ_DEPTH   4             instruction queue entries (power of 2, >= MAX_OUTST)
//  RESET_PC   32'h1c000000  address of first fetch after reset
// PORTS
//  clk               in   1   clock
//  reset             in   1   synchronous, active-high reset
//  ds_allowin        in   1   ID can accept this cycle
//  fs_to_ds_valid    out  1   queue head valid toward ID
//  fs_inst           out  32  head instruction
//  fs_pc             out  32  head PC
//  fs_adef_ex        out  1   head carries ADEF (misaligned fetch PC)
//  br_stall          in   1   suppress new requests (branch unresolved)
//  br_taken/br_target    in 1/32  branch redirect
//  wb_ex/ex_entry        in 1/32  exception redirect
//  ertn_flush/ertn_entry in 1/32  ertn redirect
//  inst_sram_req     out  1   request valid
//  inst_sram_wr      out  1   const 0
//  inst_sram_wstrb   out  4   const 0
//  inst_sram_size    out  2   const 2'b10
//  inst_sram_addr    out  32  = pf_pc
//  inst_sram_wdata   out  32  const 0
//  inst_sram_addr_ok in   1   request accepted (transfer = req & addr_ok)
//  inst_sram_data_ok in   1   one response, in request order
//  inst_sram_rdata   in   32  response data
// BEHAVIOUR
//  - Reset: pf_pc=RESET_PC, osc=0, discard_cnt=0, IQ empty, adef_hold=0; all outputs 0
//    except addr=RESET_PC, size=2'b10. Bus is reset with the core; no pre-reset responses.
//  - redirect = wb_ex|ertn_flush|br_taken; target priority wb_ex > ertn_flush > br_taken.
//  - req = ~reset & ~redirect & ~br_stall & ~adef_hold & osc<MAX_OUTST
//    & (osc + iq_count) < IQ_DEPTH (slot reserved per in-flight request; no overflow possible).
//    req may drop without addr_ok; only req&addr_ok is a transfer.
//  - Transfer: pf_pc<=pf_pc+4; PC pushed to in-flight PC FIFO (depth MAX_OUTST); osc+1.
//  - data_ok: osc-1, PC FIFO pops. If discard_cnt>0: discard_cnt-1, data dropped;
//    else {pc, rdata, adef=0} pushed to IQ. Issue and data_ok same cycle: osc unchanged.
//  - Redirect cycle: pf_pc<=target; IQ and PC FIFO cleared; adef_hold<=0; no request;
//    discard_cnt<=osc-data_ok (every surviving in-flight response becomes stale);
//    fs_to_ds_valid forced 0. Back-to-back redirects accumulate correctly (discard_cnt<=osc).
//  - ADEF: when pf_pc[1:0]!=0, not redirecting, osc==0, discard_cnt==0 and IQ has room:
//    push {pf_pc, 32'h0, adef=1}, set adef_hold (no fetch until next redirect).
//  - Output: fs_to_ds_valid = iq_count!=0 & ~redirect; head popped on valid & ds_allowin.
//    Push and pop same cycle allowed at full. Latency addr_ok->ID-visible: >=1 cycle after data_ok.
//  - Pointers wrap modulo IQ_DEPTH; iq_count width clog2(IQ_DEPTH)+1.
// CONFIGURATION
//  IF_BYPASS_EN defined: data_ok with IQ empty, discard_cnt==0, no redirect drives fs_inst/
//    fs_pc/fs_to_ds_valid combinationally same cycle; if ds_allowin the entry is not enqueued.
//  Not defined: every response enqueues; visible to ID the cycle after data_ok.
// TESTING
//  1 Reset, addr_ok/data_ok tied 1 -> addrs 1c000000,04,08..; ID sees PCs in order, no gaps.
//  2 ds_allowin=0 for 10 cycles -> iq_count=4, osc=0, req=0; release -> 4 pops, fetch resumes.
//  3 2 in flight, br_taken target 1c000100 -> discard_cnt=2, both responses dropped,
//    next ID PC=1c000100.
//  4 wb_ex and br_taken same cycle -> pf_pc=ex_entry; redirect again during discard -> count exact.
//  5 ertn_entry=1c000102 -> one ADEF entry (inst 0, fs_adef_ex=1), req stays 0 until redirect.
//  6 IF_BYPASS_EN: empty IQ, data_ok & ds_allowin -> fs_to_ds_valid same cycle, iq_count stays 0.

Source files
------------

// File: rtl/if_stage_mq_if.sv
// ---------------------------------------------------------------------------
// if_stage_mq_if : SRAM-like instruction bus between the fetch stage and the
//                  inst SRAM / AXI bridge.
//
// Signals
//   req      fetch request valid              (master -> slave)
//   wr       write enable, always 0           (master -> slave)
//   wstrb    byte strobes, always 0           (master -> slave)
//   size     transfer size, always 2'b10      (master -> slave)
//   addr     fetch address                    (master -> slave)
//   wdata    write data, always 0             (master -> slave)
//   addr_ok  request accepted this cycle      (slave -> master)
//   data_ok  one response, in request order   (slave -> master)
//   rdata    response data                    (slave -> master)
// ---------------------------------------------------------------------------
interface if_stage_mq_if;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, wstrb, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, wstrb, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/if_stage_mq.sv
// ---------------------------------------------------------------------------
// if_stage_mq : instruction-fetch stage with multiple outstanding reads.
//
// Keeps up to MAX_OUTST reads in flight on the inst bus and buffers returned
// instructions in an IQ_DEPTH-entry queue in front of ID. A redirect
// (exception > ertn > branch) flushes the queue and marks every surviving
// in-flight response as stale; stale responses are dropped by count.
//
// Parameters
//   MAX_OUTST  max accepted-but-unanswered requests (1..4)
//   IQ_DEPTH   instruction queue entries (power of 2, >= MAX_OUTST)
//   RESET_PC   address of the first fetch after reset
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   ds_allowin                      ID accepts the head this cycle
//   fs_to_ds_valid/fs_inst/fs_pc    queue head toward ID
//   fs_adef_ex                      head carries an ADEF (misaligned PC)
//   br_stall                        hold off new requests
//   br_taken/br_target              branch redirect
//   wb_ex/ex_entry                  exception redirect
//   ertn_flush/ertn_entry           ertn redirect
//   inst_sram                       instruction bus (master side)
//
// Build option
//   IF_BYPASS_EN  when defined, a response arriving with the queue empty,
//                 nothing to discard and no redirect is shown to ID in the
//                 same cycle, and is not enqueued if ID takes it.
// ---------------------------------------------------------------------------
module if_stage_mq #(
    parameter int          MAX_OUTST = 2,
    parameter int          IQ_DEPTH  = 4,
    parameter logic [31:0] RESET_PC  = 32'h1c000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ds_allowin,
    output logic          fs_to_ds_valid,
    output logic [31:0]   fs_inst,
    output logic [31:0]   fs_pc,
    output logic          fs_adef_ex,
    input  logic          br_stall,
    input  logic          br_taken,
    input  logic [31:0]   br_target,
    input  logic          wb_ex,
    input  logic [31:0]   ex_entry,
    input  logic          ertn_flush,
    input  logic [31:0]   ertn_entry,
    if_stage_mq_if.master inst_sram
);

    localparam int QW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int CW = $clog2(IQ_DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } iq_entry_t;

    // Pointer increments wrap explicitly so non-power-of-2 FIFO depths work.
    function automatic logic [QW-1:0] iq_next(input logic [QW-1:0] p);
        return (int'(p) == IQ_DEPTH - 1) ? '0 : p + QW'(1);
    endfunction

    function automatic logic [PW-1:0] pcq_next(input logic [PW-1:0] p);
        return (int'(p) == MAX_OUTST - 1) ? '0 : p + PW'(1);
    endfunction

    // ---------------------------------------------------------------- state
    logic [31:0]   pf_pc;
    logic [OW-1:0] osc;          // accepted requests still awaiting data_ok
    logic [OW-1:0] discard_cnt;  // oldest in-flight responses to drop
    logic          adef_hold;    // ADEF reported, wait for redirect

    iq_entry_t     iq_mem [IQ_DEPTH];
    logic [QW-1:0] iq_rd, iq_wr;
    logic [CW-1:0] iq_count;

    // PCs of kept in-flight requests, in issue order
    logic [31:0]   pcq_mem [MAX_OUTST];
    logic [PW-1:0] pcq_rd, pcq_wr;

    // ----------------------------------------------------------- comb logic
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        pc_misalign;
    logic        discarding;
    logic        xfer;
    logic        rsp;
    logic        rsp_keep;
    logic        adef_push;
    logic        bypass;
    logic        push;
    logic        pop;
    logic        iq_nonempty;
    iq_entry_t   push_entry;

    assign redirect    = wb_ex | ertn_flush | br_taken;
    assign redirect_pc = wb_ex      ? ex_entry   :
                         ertn_flush ? ertn_entry : br_target;
    assign pc_misalign = pf_pc[1:0] != 2'b00;
    assign discarding  = discard_cnt != '0;
    assign iq_nonempty = iq_count != '0;

    // Every in-flight request holds a queue slot, so the queue cannot
    // overflow when its response returns. A misaligned PC is never put on
    // the bus; it is reported as ADEF instead.
    assign inst_sram.req = ~reset & ~redirect & ~br_stall & ~adef_hold & ~pc_misalign
                         & (int'(osc) < MAX_OUTST)
                         & (int'(osc) + int'(iq_count) < IQ_DEPTH);
    assign inst_sram.wr    = 1'b0;
    assign inst_sram.wstrb = 4'h0;
    assign inst_sram.size  = 2'b10;
    assign inst_sram.addr  = pf_pc;
    assign inst_sram.wdata = 32'h0;

    assign xfer     = inst_sram.req & inst_sram.addr_ok;
    assign rsp      = inst_sram.data_ok;
    assign rsp_keep = rsp & ~discarding & ~redirect;

    // ADEF waits until the bus is quiet so it lands behind all older fetches.
    assign adef_push = pc_misalign & ~redirect & ~adef_hold & (osc == '0)
                     & ~discarding & (int'(iq_count) < IQ_DEPTH);

`ifdef IF_BYPASS_EN
    assign bypass = rsp_keep & ~iq_nonempty;
`else
    assign bypass = 1'b0;
`endif

    assign fs_to_ds_valid = (iq_nonempty | bypass) & ~redirect;
    assign pop  = iq_nonempty & fs_to_ds_valid & ds_allowin;
    assign push = (rsp_keep & ~(bypass & ds_allowin)) | adef_push;

    always_comb begin
        push_entry = '{pc: pcq_mem[pcq_rd], inst: inst_sram.rdata, adef: 1'b0};
        if (adef_push) begin
            push_entry = '{pc: pf_pc, inst: 32'h0, adef: 1'b1};
        end
    end

    always_comb begin
        fs_pc      = iq_mem[iq_rd].pc;
        fs_inst    = iq_mem[iq_rd].inst;
        fs_adef_ex = iq_mem[iq_rd].adef;
        if (bypass) begin
            fs_pc      = pcq_mem[pcq_rd];
            fs_inst    = inst_sram.rdata;
            fs_adef_ex = 1'b0;
        end
    end

    // ----------------------------------------------------------- sequential
    always_ff @(posedge clk) begin
        if (reset) begin
            pf_pc       <= RESET_PC;
            osc         <= '0;
            discard_cnt <= '0;
            adef_hold   <= 1'b0;
            iq_rd       <= '0;
            iq_wr       <= '0;
            iq_count    <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                iq_mem[i] <= '0;
            end
            for (int i = 0; i < MAX_OUTST; i++) begin
                pcq_mem[i] <= '0;
            end
        end else begin
            // No request issues during a redirect, so xfer and redirect
            // never coincide.
            osc <= osc + OW'(xfer) - OW'(rsp);

            if (redirect) begin
                pf_pc       <= redirect_pc;
                // Everything still outstanding after this cycle is stale,
                // including responses already counted for an earlier redirect.
                discard_cnt <= osc - OW'(rsp);
                adef_hold   <= 1'b0;
                iq_rd       <= '0;
                iq_wr       <= '0;
                iq_count    <= '0;
                pcq_rd      <= '0;
                pcq_wr      <= '0;
            end else begin
                if (xfer) begin
                    pf_pc           <= pf_pc + 32'd4;
                    pcq_mem[pcq_wr] <= pf_pc;
                    pcq_wr          <= pcq_next(pcq_wr);
                end

                // Stale responses never had their PC queued here, so only
                // kept responses advance the PC FIFO.
                if (rsp & discarding) begin
                    discard_cnt <= discard_cnt - OW'(1);
                end else if (rsp) begin
                    pcq_rd <= pcq_next(pcq_rd);
                end

                if (adef_push) begin
                    adef_hold <= 1'b1;
                end

                if (push) begin
                    iq_mem[iq_wr] <= push_entry;
                    iq_wr         <= iq_next(iq_wr);
                end
                if (pop) begin
                    iq_rd <= iq_next(iq_rd);
                end
                iq_count <= iq_count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule
